seq_counter: RTL
================

# seq_counter

Parametrised synchronous sequence counter: the general-purpose successor to the team's fixed 3-bit JK sequence counter. Provides binary up, binary down, Gray and Johnson sequences of configurable width with load, enable, saturate-or-wrap and terminal-count flags. It sits in the datapath as a timing and sequencing source, and its optional prescaler produces slow visible counts from the board clock through a clock enable, not a derived clock.

## Interface
- WIDTH, 3, counter width in bits, legal range 2..16
- MAX_VAL, 2**WIDTH-1, top value for the binary and Gray modes, legal range 1..2**WIDTH-1
- PRESCALE_W, 24, prescaler width (used only with the macro)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable
- mode  in  2  sequence select: 0 binary up, 1 binary down, 2 Gray up, 3 Johnson
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- stop_at_tc  in  1  1 = hold at terminal value, 0 = wrap
- prescale  in  PRESCALE_W  step every prescale+1 enabled cycles; ignored without the macro
- count  out  WIDTH  current sequence value
- tc  out  1  count equals the terminal value of the active mode
- wrap  out  1  one-cycle pulse after a terminal-to-start step

## Operation
- Internal state is q[WIDTH-1:0] plus the registered mode mode_q.
- count = q in modes 0, 1 and 3. In mode 2, count = q ^ (q >> 1): q holds a binary value and the output is its Gray code.
- Start and terminal values per mode:
  - up: start 0, terminal MAX_VAL
  - down: start MAX_VAL, terminal 0
  - Gray: internal start 0, internal terminal MAX_VAL
  - Johnson: start all-zero, terminal {1, 0...0}, giving a sequence of length 2*WIDTH
- Step rules:
  - up: q+1, and q returns to start after terminal
  - down: q-1, with the same return to start
  - Gray: same as up on q
  - Johnson: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}
- Priority on each edge: load, then mode change, then step.
  - load: q <= load_val. In modes 0–2, values above MAX_VAL are clamped to MAX_VAL. In Johnson mode the value is loaded unmodified; an illegal pattern circulates and is never corrected.
  - mode change (mode != mode_q with load low): q <= start value of the new mode, mode_q <= mode, no step that cycle.
  - step: taken when en is high and the tick is high. If stop_at_tc is high and tc is high, q holds and no wrap is produced.
- tc is a combinational decode of q and mode_q.
- wrap is registered. It goes high for exactly one cycle following a step from terminal to start. Load and mode change never assert wrap.
- Width: all arithmetic is done at WIDTH bits. MAX_VAL compare is exact; there is no modulo-2**WIDTH aliasing when MAX_VAL < 2**WIDTH-1.

## Timing
- Reset (async assert, synchronous release): q=0, mode_q=0, wrap=0, prescaler=0; therefore count=0 and tc=0.
- Latency:
  - load, mode change and step are each visible on count one edge after being sampled.
  - tc follows count in the same cycle.
  - wrap is high during the cycle in which count first shows the start value.
- en low freezes q and the prescaler; tc stays valid.
- rst asserted mid-sequence clears state immediately, regardless of clk.

## Configuration
- SEQ_COUNTER_PRESCALE_EN defined:
  - A PRESCALE_W-bit prescaler advances on each cycle with en high.
  - tick = (prescaler == prescale), and the prescaler returns to 0 on tick.
  - load and mode change clear the prescaler.
  - prescale=0 gives a step every enabled cycle.
- Not defined: tick is tied to 1, the prescale input is ignored, and no prescaler flops exist.

## Structure
- Package seq_counter_pkg holds:
  - mode enum (MODE_UP, MODE_DOWN, MODE_GRAY, MODE_JOHNSON)
  - functions bin2gray, start_val(mode, MAX_VAL) and term_val(mode, MAX_VAL)
- Sub-module seq_prescaler (tick generator). It is instantiated only under SEQ_COUNTER_PRESCALE_EN.

## Test plan
- WIDTH=3, mode 0, en=1, stop_at_tc=0: count 0..7 then 0. tc high at 7. wrap high only during the cycle count=0 after 7.
- WIDTH=3, MAX_VAL=5, mode 1, load 7: count=5 (clamped), then 4,3,2,1,0 with tc at 0, then 5 with wrap.
- WIDTH=3, mode 2 from reset: count 0,1,3,2,6,7,5,4,0; exactly one output bit changes per step.
- WIDTH=3, mode 3: count 000,001,011,111,110,100,000. tc at 100. stop_at_tc=1 holds at 100 with no wrap.
- Switch mode 0→1 at count=4 while en=1: next count=7 (start of down), no wrap. rst pulse mid-count: count=0 immediately, without waiting for a clock edge.
- With SEQ_COUNTER_PRESCALE_EN and prescale=3: count advances once per 4 enabled cycles. Dropping en for 2 cycles delays the next step by 2 cycles.

Source files
------------

// File: rtl/seq_counter_pkg.sv
// -----------------------------------------------------------------------------
// seq_counter_pkg
// Shared types and helpers for the parametrised sequence counter.
//   mode_e     : sequence select (binary up, binary down, Gray up, Johnson)
//   word_t     : widest supported counter word; callers size-cast the result
//   bin2gray   : binary to reflected Gray code
//   start_val  : first value of a sequence for a given mode
//   term_val   : terminal value of a sequence for a given mode
// -----------------------------------------------------------------------------
package seq_counter_pkg;

    localparam int MAX_WIDTH = 16;

    typedef logic [MAX_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        MODE_UP      = 2'd0,
        MODE_DOWN    = 2'd1,
        MODE_GRAY    = 2'd2,
        MODE_JOHNSON = 2'd3
    } mode_e;

    function automatic word_t bin2gray(input word_t v);
        return v ^ (v >> 1);
    endfunction

    // Gray mode counts a binary value internally, so it shares the up start.
    function automatic word_t start_val(input mode_e m, input word_t max_val);
        return (m == MODE_DOWN) ? max_val : '0;
    endfunction

    // Johnson terminal is the single MSB pattern {1, 0...0}, so it needs the
    // actual counter width rather than the top value.
    function automatic word_t term_val(input mode_e m, input word_t max_val,
                                       input int width);
        word_t r;
        case (m)
            MODE_UP, MODE_GRAY: r = max_val;
            MODE_DOWN:          r = '0;
            MODE_JOHNSON:       r = word_t'(1) << (width - 1);
            default:            r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_prescaler.sv
// -----------------------------------------------------------------------------
// seq_prescaler
// Clock-enable tick generator for the sequence counter. The internal counter
// advances on every enabled cycle and returns to zero when it reaches the
// programmed prescale value, so o_tick is high once per (prescale+1) enabled
// cycles. No derived clock is produced.
// Ports:
//   clk        : clock, posedge
//   rst        : asynchronous active-high reset
//   i_en       : advance enable; low freezes the counter
//   i_clear    : synchronous clear (load / mode change in the parent)
//   i_prescale : terminal value of the prescaler counter
//   o_tick     : combinational, high while the counter equals i_prescale
// -----------------------------------------------------------------------------
module seq_prescaler #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clear,
    input  logic [W-1:0] i_prescale,
    output logic         o_tick
);

    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == i_prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_counter.sv
// -----------------------------------------------------------------------------
// seq_counter
// Parametrised synchronous sequence counter: binary up, binary down, Gray and
// Johnson sequences with load, enable, saturate-or-wrap and terminal count.
// Optional feature macro: SEQ_COUNTER_PRESCALE_EN
//   defined   : a seq_prescaler gates steps to once per (prescale+1) enabled
//               cycles
//   undefined : every enabled cycle steps; prescale is ignored
// Ports:
//   clk        : clock, posedge
//   rst        : asynchronous active-high reset
//   en         : count enable
//   mode       : 0 up, 1 down, 2 Gray, 3 Johnson
//   load       : synchronous load of load_val (highest priority)
//   load_val   : value to load (clamped to MAX_VAL outside Johnson mode)
//   stop_at_tc : 1 holds at terminal value, 0 wraps to start
//   prescale   : prescaler terminal value
//   count      : current sequence value (Gray-coded in mode 2)
//   tc         : count is at the terminal value of the registered mode
//   wrap       : one-cycle pulse while count first shows the start value
// -----------------------------------------------------------------------------
module seq_counter
    import seq_counter_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int MAX_VAL    = 2**WIDTH - 1,
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  stop_at_tc,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap
);

    localparam word_t           MAX_WORD = word_t'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_q;
    mode_e            r_mode;
    logic             r_wrap;

    mode_e            w_mode_in;
    logic             w_mode_change;
    logic             w_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_new_start;
    logic [WIDTH-1:0] w_cur_start;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_next;

    assign w_mode_in     = mode_e'(mode);
    assign w_mode_change = (w_mode_in != r_mode);

    assign w_new_start = WIDTH'(start_val(w_mode_in, MAX_WORD));
    assign w_cur_start = WIDTH'(start_val(r_mode, MAX_WORD));
    assign w_term      = WIDTH'(term_val(r_mode, MAX_WORD, WIDTH));

    // Johnson loads are taken verbatim; an illegal pattern is left to circulate.
    assign w_load_q = (r_mode != MODE_JOHNSON && load_val > MAX_Q) ? MAX_Q : load_val;

`ifdef SEQ_COUNTER_PRESCALE_EN
    seq_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_clear    (load | w_mode_change),
        .i_prescale (prescale),
        .o_tick     (w_tick)
    );
`else
    logic w_unused_prescale;
    assign w_unused_prescale = ^prescale;
    assign w_tick            = 1'b1;
`endif

    assign w_step = en & w_tick;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_q;
        case (r_mode)
            MODE_UP, MODE_GRAY: w_next = r_q + WIDTH'(1);
            MODE_DOWN:          w_next = r_q - WIDTH'(1);
            MODE_JOHNSON:       w_next = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            default:            w_next = r_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_mode <= MODE_UP;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (load) begin
                r_q <= w_load_q;
            end else if (w_mode_change) begin
                r_q    <= w_new_start;
                r_mode <= w_mode_in;
            end else if (w_step) begin
                if (tc) begin
                    // Saturating mode holds silently; wrapping mode restarts.
                    if (!stop_at_tc) begin
                        r_q    <= w_cur_start;
                        r_wrap <= 1'b1;
                    end
                end else begin
                    r_q <= w_next;
                end
            end
        end
    end

    assign tc    = (r_q == w_term);
    assign wrap  = r_wrap;
    assign count = (r_mode == MODE_GRAY) ? WIDTH'(bin2gray(word_t'(r_q))) : r_q;

endmodule
